// File: rtl/sample_unpacker.sv
// rtl/sample_unpacker.sv - unpacks WORD_W-bit FIFO words into SAMPLE_W-bit samples
//
// Reads words from a show-ahead FIFO and emits one SAMPLE_W-bit sample for each
// sample_en. Bits that cross a word boundary are joined into one sample.
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   word_data        FIFO head word, valid while word_valid is high
//   word_valid       FIFO is not empty
//   word_rd_req      combinational pop; the head word is captured on the same edge
//   sample_en        consumer asks for one sample this cycle
//   flush            discards every buffered bit
//   sample_data      registered sample
//   sample_valid     one-cycle strobe, high when sample_data is new
//   underflow        one-cycle strobe: sample_en arrived with too few bits buffered
//   underflow_count  count of underflow events, saturating at all-ones
//   fill_bits        number of bits currently buffered
module sample_unpacker #(
  parameter int WORD_W    = 16,
  parameter int SAMPLE_W  = 3,
  parameter int LSB_FIRST = 1,
  parameter int UF_CNT_W  = 16,
  localparam int BUF_W    = WORD_W + SAMPLE_W - 1,
  localparam int CNT_W    = $clog2(WORD_W + SAMPLE_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                word_valid,
  output logic                word_rd_req,
  input  logic                sample_en,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  output logic                underflow,
  output logic [UF_CNT_W-1:0] underflow_count,
  output logic [CNT_W-1:0]    fill_bits
);

  logic [BUF_W-1:0]    bits_q, bits_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
  logic                sample_valid_q, sample_valid_d;
  logic                underflow_q, underflow_d;
  logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;

  logic [WORD_W-1:0]   word_ord;
  logic [SAMPLE_W-1:0] sample_ord;
  logic [BUF_W-1:0]    bits_sh;
  logic [CNT_W-1:0]    cnt_after;
  logic                take;
  logic                fetch;

  always_comb begin
    // The core always consumes from bit 0 upwards; MSB-first mode reverses
    // words on entry and samples on exit so that ordering inside a sample is kept.
    word_ord   = '0;
    sample_ord = '0;
    for (int i = 0; i < WORD_W; i++) begin
      word_ord[i] = (LSB_FIRST != 0) ? word_data[i] : word_data[WORD_W-1-i];
    end
    for (int i = 0; i < SAMPLE_W; i++) begin
      sample_ord[i] = (LSB_FIRST != 0) ? bits_q[i] : bits_q[SAMPLE_W-1-i];
    end

    take      = sample_en && (cnt_q >= CNT_W'(SAMPLE_W));
    bits_sh   = take ? (bits_q >> SAMPLE_W) : bits_q;
    cnt_after = take ? (cnt_q - CNT_W'(SAMPLE_W)) : cnt_q;
    // A refill is only requested below one sample's worth of bits, which
    // bounds cnt at SAMPLE_W-1+WORD_W = BUF_W, so the buffer can never overflow.
    fetch     = word_valid && (cnt_after < CNT_W'(SAMPLE_W)) && !reset && !flush;

    bits_d         = bits_sh;
    cnt_d          = cnt_after;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    underflow_d    = 1'b0;
    uf_cnt_d       = uf_cnt_q;

    if (fetch) begin
      bits_d = bits_sh | (BUF_W'(word_ord) << cnt_after);
      cnt_d  = cnt_after + CNT_W'(WORD_W);
    end

    if (take) begin
      sample_data_d  = sample_ord;
      sample_valid_d = 1'b1;
    end else if (sample_en) begin
      // Partial bits stay in the buffer and will lead the next sample.
      sample_data_d = '0;
      underflow_d   = 1'b1;
      if (uf_cnt_q != {UF_CNT_W{1'b1}}) begin
        uf_cnt_d = uf_cnt_q + 1'b1;
      end
    end

    if (flush) begin
      bits_d         = '0;
      cnt_d          = '0;
      sample_data_d  = sample_data_q;
      sample_valid_d = 1'b0;
      underflow_d    = 1'b0;
      uf_cnt_d       = uf_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q         <= '0;
      cnt_q          <= '0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      underflow_q    <= 1'b0;
      uf_cnt_q       <= '0;
    end else begin
      bits_q         <= bits_d;
      cnt_q          <= cnt_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      underflow_q    <= underflow_d;
      uf_cnt_q       <= uf_cnt_d;
    end
  end

  assign word_rd_req     = fetch;
  assign sample_data     = sample_data_q;
  assign sample_valid    = sample_valid_q;
  assign underflow       = underflow_q;
  assign underflow_count = uf_cnt_q;
  assign fill_bits       = cnt_q;

endmodule

// File: tb/tb_sample_unpacker.sv
// tb/tb_sample_unpacker.sv - scoreboard bench for sample_unpacker in four configurations
module tb_sample_unpacker;

  localparam int WW  [4] = '{16, 16, 8, 16};
  localparam int SW  [4] = '{3, 3, 8, 1};
  localparam int LSB [4] = '{1, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] wd [4];
  logic        wv [4];
  logic        en [4];
  logic        fl [4];

  logic        rd_a, rd_b, rd_c, rd_d;
  logic [2:0]  sd_a, sd_b;
  logic [7:0]  sd_c;
  logic [0:0]  sd_d;
  logic        sv_a, sv_b, sv_c, sv_d;
  logic        uf_a, uf_b, uf_c, uf_d;
  logic [15:0] ufc_a, ufc_c, ufc_d;
  logic [1:0]  ufc_b;
  logic [4:0]  fb_a, fb_b, fb_d;
  logic [3:0]  fb_c;

  logic        rd  [4];
  logic        sv  [4];
  logic        uf  [4];
  logic [15:0] sd  [4];
  logic [15:0] ufc [4];
  logic [15:0] fb  [4];
  logic        rdc [4];

  logic [15:0] fifo [4][$];
  logic [15:0] expq [4][$];
  bit          bitq [4][$];
  int          nrd [4];
  int          nval [4];
  int          n_tests = 0;
  int          n_fail = 0;

  sample_unpacker #(.WORD_W(16), .SAMPLE_W(3), .LSB_FIRST(1), .UF_CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .word_data(wd[0]), .word_valid(wv[0]), .word_rd_req(rd_a),
    .sample_en(en[0]), .flush(fl[0]), .sample_data(sd_a), .sample_valid(sv_a),
    .underflow(uf_a), .underflow_count(ufc_a), .fill_bits(fb_a));

  sample_unpacker #(.WORD_W(16), .SAMPLE_W(3), .LSB_FIRST(0), .UF_CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .word_data(wd[1]), .word_valid(wv[1]), .word_rd_req(rd_b),
    .sample_en(en[1]), .flush(fl[1]), .sample_data(sd_b), .sample_valid(sv_b),
    .underflow(uf_b), .underflow_count(ufc_b), .fill_bits(fb_b));

  sample_unpacker #(.WORD_W(8), .SAMPLE_W(8), .LSB_FIRST(1), .UF_CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .word_data(wd[2][7:0]), .word_valid(wv[2]), .word_rd_req(rd_c),
    .sample_en(en[2]), .flush(fl[2]), .sample_data(sd_c), .sample_valid(sv_c),
    .underflow(uf_c), .underflow_count(ufc_c), .fill_bits(fb_c));

  sample_unpacker #(.WORD_W(16), .SAMPLE_W(1), .LSB_FIRST(1), .UF_CNT_W(16)) u_d (
    .clk(clk), .reset(reset), .word_data(wd[3]), .word_valid(wv[3]), .word_rd_req(rd_d),
    .sample_en(en[3]), .flush(fl[3]), .sample_data(sd_d), .sample_valid(sv_d),
    .underflow(uf_d), .underflow_count(ufc_d), .fill_bits(fb_d));

  always_comb begin
    rd[0] = rd_a;  rd[1] = rd_b;  rd[2] = rd_c;  rd[3] = rd_d;
    sv[0] = sv_a;  sv[1] = sv_b;  sv[2] = sv_c;  sv[3] = sv_d;
    uf[0] = uf_a;  uf[1] = uf_b;  uf[2] = uf_c;  uf[3] = uf_d;
    sd[0] = 16'(sd_a);   sd[1] = 16'(sd_b);   sd[2] = 16'(sd_c);   sd[3] = 16'(sd_d);
    ufc[0] = ufc_a;      ufc[1] = 16'(ufc_b); ufc[2] = ufc_c;      ufc[3] = ufc_d;
    fb[0] = 16'(fb_a);   fb[1] = 16'(fb_b);   fb[2] = 16'(fb_c);   fb[3] = 16'(fb_d);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Appends a word to the FIFO of instance i and to that instance's bit stream,
  // then cuts every complete sample out of the stream into the expected queue.
  task automatic push_word(input int i, input logic [15:0] w);
    logic [15:0] s;
    bit          x;
    fifo[i].push_back(w);
    for (int b = 0; b < WW[i]; b++) begin
      bitq[i].push_back((LSB[i] != 0) ? w[b] : w[WW[i]-1-b]);
    end
    while (bitq[i].size() >= SW[i]) begin
      s = '0;
      for (int k = 0; k < SW[i]; k++) begin
        x = bitq[i].pop_front();
        if (LSB[i] != 0) s[k] = x;
        else             s[SW[i]-1-k] = x;
      end
      expq[i].push_back(s);
    end
  endtask

  task automatic clear_model(input int i);
    expq[i].delete();
    bitq[i].delete();
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wv[i] = (fifo[i].size() != 0);
      wd[i] = wv[i] ? fifo[i][0] : 16'h0;
    end
    #1;
    for (int i = 0; i < 4; i++) rdc[i] = rd[i];
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rdc[i]) begin
        nrd[i]++;
        void'(fifo[i].pop_front());
      end
      if (sv[i]) begin
        nval[i]++;
        if (expq[i].size() == 0) check($sformatf("unexpected_valid_%0d", i), 32'd1, 32'd0);
        else check($sformatf("sample_%0d", i), 32'(sd[i]), 32'(expq[i].pop_front()));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en[i] = 1'b0; fl[i] = 1'b0; wv[i] = 1'b0; wd[i] = 16'h0;
      nrd[i] = 0; nval[i] = 0;
    end
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_sv_%0d", i), 32'(sv[i]), 32'd0);
      check($sformatf("rst_uf_%0d", i), 32'(uf[i]), 32'd0);
      check($sformatf("rst_sd_%0d", i), 32'(sd[i]), 32'd0);
      check($sformatf("rst_ufc_%0d", i), 32'(ufc[i]), 32'd0);
      check($sformatf("rst_fb_%0d", i), 32'(fb[i]), 32'd0);
    end
    reset = 1'b0;

    // Bit order: LSB-first on A, MSB-first on B, same two words.
    push_word(0, 16'hFAC5); push_word(0, 16'h0000);
    push_word(1, 16'hFAC5); push_word(1, 16'h0000);
    cycle();
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (10) cycle();
    en[0] = 1'b0; en[1] = 1'b0;
    cycle();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("order_rd_pulses_%0d", i), 32'(nrd[i]), 32'd2);
      check($sformatf("order_nvalid_%0d", i), 32'(nval[i]), 32'd10);
      check($sformatf("order_fill_%0d", i), 32'(fb[i]), 32'd2);
      check($sformatf("order_ufc_%0d", i), 32'(ufc[i]), 32'd0);
    end

    // Underflow with two partial bits and an empty FIFO.
    en[0] = 1'b1;
    cycle();
    en[0] = 1'b0;
    check("uf_pulse", 32'(uf[0]), 32'd1);
    check("uf_sv", 32'(sv[0]), 32'd0);
    check("uf_sd", 32'(sd[0]), 32'd0);
    check("uf_count", 32'(ufc[0]), 32'd1);
    check("uf_fill_kept", 32'(fb[0]), 32'd2);
    cycle();
    check("uf_one_cycle", 32'(uf[0]), 32'd0);

    // Saturation of a 2-bit counter.
    en[1] = 1'b1;
    repeat (5) cycle();
    en[1] = 1'b0;
    check("sat_count", 32'(ufc[1]), 32'd3);
    check("sat_fill_kept", 32'(fb[1]), 32'd2);
    cycle();

    // Flush with sample_en high, then three words streamed back to back.
    fl[0] = 1'b1; en[0] = 1'b1;
    cycle();
    fl[0] = 1'b0; en[0] = 1'b0;
    clear_model(0);
    check("flush_sv", 32'(sv[0]), 32'd0);
    check("flush_uf", 32'(uf[0]), 32'd0);
    check("flush_fill", 32'(fb[0]), 32'd0);
    check("flush_ufc_kept", 32'(ufc[0]), 32'd1);
    for (int k = 0; k < 3; k++) push_word(0, 16'($urandom));
    cycle();
    en[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      check($sformatf("stream_nogap_%0d", k), 32'(sv[0]), 32'd1);
    end
    cycle();
    en[0] = 1'b0;
    check("stream_17th_uf", 32'(uf[0]), 32'd1);
    check("stream_17th_sv", 32'(sv[0]), 32'd0);
    check("stream_fill", 32'(fb[0]), 32'd0);

    // Reset in the middle of a word.
    push_word(0, 16'h9D2B);
    cycle();
    en[0] = 1'b1;
    repeat (2) cycle();
    en[0] = 1'b0;
    check("mid_fill", 32'(fb[0]), 32'd10);
    for (int i = 0; i < 4; i++) clear_model(i);
    push_word(0, 16'h6E31);
    reset = 1'b1;
    cycle();
    check("rst_mid_sd", 32'(sd[0]), 32'd0);
    check("rst_mid_sv", 32'(sv[0]), 32'd0);
    check("rst_mid_uf", 32'(uf[0]), 32'd0);
    check("rst_mid_ufc", 32'(ufc[0]), 32'd0);
    check("rst_mid_fill", 32'(fb[0]), 32'd0);
    cycle();
    check("rst_no_rd_req", 32'(rdc[0]), 32'd0);
    reset = 1'b0;
    cycle();
    en[0] = 1'b1;
    repeat (5) cycle();
    en[0] = 1'b0;
    check("restart_fill", 32'(fb[0]), 32'd1);

    // 8/8 passthrough.
    push_word(2, 16'h003C); push_word(2, 16'h00A7); push_word(2, 16'h005E);
    cycle();
    en[2] = 1'b1;
    repeat (3) cycle();
    en[2] = 1'b0;
    check("pass_nvalid", 32'(nval[2]), 32'd3);
    check("pass_fill", 32'(fb[2]), 32'd0);

    // 8/8 flush discards a buffered word.
    push_word(2, 16'h00C1); push_word(2, 16'h0019);
    cycle();
    en[2] = 1'b1;
    cycle();
    en[2] = 1'b0;
    check("pass_prefill", 32'(fb[2]), 32'd8);
    fl[2] = 1'b1;
    cycle();
    fl[2] = 1'b0;
    clear_model(2);
    check("pass_flush_fill", 32'(fb[2]), 32'd0);
    en[2] = 1'b1;
    cycle();
    en[2] = 1'b0;
    check("pass_flush_uf", 32'(uf[2]), 32'd1);
    check("pass_flush_ufc", 32'(ufc[2]), 32'd1);

    // 16/1 serial bits, flush mid-word keeps the underflow count.
    en[3] = 1'b1;
    cycle();
    en[3] = 1'b0;
    check("serial_uf_count", 32'(ufc[3]), 32'd1);
    push_word(3, 16'hA5C3);
    cycle();
    en[3] = 1'b1;
    repeat (5) cycle();
    en[3] = 1'b0;
    check("serial_fill", 32'(fb[3]), 32'd11);
    fl[3] = 1'b1; en[3] = 1'b1;
    cycle();
    fl[3] = 1'b0; en[3] = 1'b0;
    clear_model(3);
    check("serial_flush_sv", 32'(sv[3]), 32'd0);
    check("serial_flush_uf", 32'(uf[3]), 32'd0);
    check("serial_flush_fill", 32'(fb[3]), 32'd0);
    check("serial_flush_ufc", 32'(ufc[3]), 32'd1);
    push_word(3, 16'h0001);
    cycle();
    en[3] = 1'b1;
    repeat (3) cycle();
    en[3] = 1'b0;
    check("serial_refill", 32'(fb[3]), 32'd13);

    check("drain_a", 32'(expq[0].size()), 32'd0);
    check("drain_b", 32'(expq[1].size()), 32'd0);
    check("drain_c", 32'(expq[2].size()), 32'd0);
    check("drain_d", 32'(expq[3].size()), 32'd13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_unpacker.md
Name: sample_unpacker

Overview:
- Parametrised successor to the fixed 16b-word / 3b-sample unpacker in the real-time data feed.
- Pulls WORD_W-bit words from a show-ahead FIFO and emits SAMPLE_W-bit samples on demand.
- Bits that straddle word boundaries are carried exactly, for any WORD_W/SAMPLE_W ratio.
- Adds selectable bit order, flush, an explicit sample_valid, and underflow detection/counting; sits between the RX FIFO read side and the sample consumer.

Parameters:
WORD_W, 16, width of each FIFO word.
SAMPLE_W, 3, width of each output sample; legal range 1..WORD_W.
LSB_FIRST, 1, 1 = first sample is word[SAMPLE_W-1:0]; 0 = first sample is word[WORD_W-1 -: SAMPLE_W]. Bit order inside a sample is preserved in both modes.
UF_CNT_W, 16, width of the underflow counter.

Ports:
clk  input  1  Sole clock; all logic on rising edge.
reset  input  1  Synchronous, active-high reset.
word_data  input  WORD_W  FIFO head word (show-ahead); valid while word_valid=1.
word_valid  input  1  FIFO not empty.
word_rd_req  output  1  Combinational pop; head word is captured on the same edge.
sample_en  input  1  Consumer requests one sample this cycle.
flush  input  1  Synchronous discard of all buffered bits.
sample_data  output  SAMPLE_W  Registered sample.
sample_valid  output  1  Registered; 1 for one cycle when sample_data is new.
underflow  output  1  Registered one-cycle pulse: sample_en with too few bits buffered.
underflow_count  output  UF_CNT_W  Saturating count of underflow events.
fill_bits  output  clog2(WORD_W+SAMPLE_W)  Current buffered bit count (debug).

Behaviour:
- Internal state:
  - Bit buffer buf, width BUF_W = WORD_W+SAMPLE_W-1.
  - Count cnt, range 0..BUF_W.
  - For LSB_FIRST=0, words are bit-reversed on entry and samples bit-reversed on exit; the core always consumes from buf[SAMPLE_W-1:0].
- Reset (highest priority): buf, cnt, sample_data, sample_valid, underflow, underflow_count all 0. word_rd_req=0 while reset=1.
- Flush (next priority): buf=0, cnt=0, word_rd_req=0, sample_valid=0, underflow=0. sample_en is ignored that cycle. underflow_count is kept.
- Consume: take=sample_en && cnt>=SAMPLE_W.
  - On take: sample_data<=buf[SAMPLE_W-1:0] (mapped per LSB_FIRST), sample_valid<=1, buf shifts right by SAMPLE_W.
  - Latency: sample appears one cycle after sample_en.
- Underflow: sample_en && cnt<SAMPLE_W.
  - sample_data<=0, sample_valid<=0, underflow<=1.
  - underflow_count increments, saturating at all-ones.
  - Partial bits are retained, not dropped.
- Fetch: cnt_after = cnt - (take ? SAMPLE_W : 0).
  - word_rd_req = word_valid && cnt_after<SAMPLE_W && !reset && !flush.
  - On fetch: the word is ORed into buf at bit position cnt_after, and cnt<=cnt_after+WORD_W.
  - This guarantees cnt never exceeds BUF_W, so no overflow is possible.
- Take and fetch in the same cycle are legal. The sample always comes from the bits present before the append.
- A word fetched at cycle N is consumable at cycle N+1. When cnt<SAMPLE_W and the FIFO is non-empty, at most one cycle passes before refill.
- Unused high buffer bits are held at 0.
- sample_valid and underflow are 0 in every cycle without sample_en.
- fill_bits = cnt.

Test Plan:
- LSB_FIRST=1, words 0xFAC5 then 0x0000, sample_en held high after the first fetch -> samples 5,0,3,5,7, then 1 (carry bit15 + next word bits[1:0]), then 0s. word_rd_req pulses exactly twice.
- LSB_FIRST=0, same words -> samples 7,6,5,4,2, then 4 (leftover bit0=1 + top two zeros of 0x0000).
- Empty FIFO, one sample_en pulse -> next cycle underflow=1, sample_valid=0, sample_data=0, underflow_count=1, fill_bits unchanged. With UF_CNT_W=2, 5 events -> underflow_count saturates at 3.
- Three words queued, sample_en continuous -> exactly 16 valid samples with no gaps after the first fill; fill_bits=0 afterwards; 17th request raises underflow.
- Reset asserted mid-stream with fill_bits=10 -> next cycle all outputs 0, fill_bits=0, no word_rd_req while reset=1. After release, decoding restarts cleanly at the next word's bit 0.
- WORD_W=8, SAMPLE_W=8 and WORD_W=16, SAMPLE_W=1 -> 1:1 word passthrough and serial bit order respectively; flush mid-word discards the remaining bits; underflow_count is kept.
